// File: rtl/pc_redirect_ctrl.sv
// Purpose: IF PC-mux redirect controller with trap/MRET sequencing, machine CSRs and pipeline flush.
// Latency: pc_sel/flush combinational in the event cycle; CSR and FSM updates land on the next edge.
// Backpressure: none; the pipeline is killed for FLUSH_CYCLES after a redirect and events are ignored meanwhile.
// Optional feature: define PC_REDIRECT_VECTORED_EN for vectored mtvec (mtvec[0]=1 -> interrupts at base+4*cause).
module pc_redirect_ctrl #(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_taken_ex,
    input  logic [WIDTH-1:0] br_target_in,
    input  logic             exc_req,
    input  logic [4:0]       exc_cause,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             irq,
    input  logic             mret_ex,
    input  logic             csr_we,
    input  logic [11:0]      csr_addr,
    input  logic [WIDTH-1:0] csr_wdata,
    output logic [1:0]       pc_sel,
    output logic [WIDTH-1:0] br_target,
    output logic [WIDTH-1:0] mtvec,
    output logic [WIDTH-1:0] mepc,
    output logic [WIDTH-1:0] mcause,
    output logic             mie,
    output logic             flush
);

    localparam logic [11:0]      ADDR_MSTATUS = 12'h300;
    localparam logic [11:0]      ADDR_MTVEC   = 12'h305;
    localparam logic [11:0]      ADDR_MEPC    = 12'h341;
    localparam logic [11:0]      ADDR_MCAUSE  = 12'h342;
    localparam logic [WIDTH-1:0] ALIGN_MASK   = ~WIDTH'(3);
    localparam int               IRQ_CODE     = 11;
    localparam logic [WIDTH-1:0] IRQ_MCAUSE   = {1'b1, (WIDTH-1)'(IRQ_CODE)};
    localparam logic [1:0]       CNT_LOAD     = 2'(FLUSH_CYCLES - 1);

    localparam logic [1:0] SEL_PC4  = 2'd0;
    localparam logic [1:0] SEL_BR   = 2'd1;
    localparam logic [1:0] SEL_TVEC = 2'd2;
    localparam logic [1:0] SEL_EPC  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_mtvec;
    logic [WIDTH-1:0] r_mepc;
    logic [WIDTH-1:0] r_mcause;
    logic             r_mie;
    logic             r_mpie;

    // Event decode: only in IDLE and out of reset, priority exc > irq > mret > branch.
    logic w_idle;
    logic w_take_exc;
    logic w_take_irq;
    logic w_take_mret;
    logic w_take_br;
    logic w_event;

    assign w_idle      = rst_n && (r_state == IDLE);
    assign w_take_exc  = w_idle && exc_req;
    assign w_take_irq  = w_idle && !exc_req && irq && r_mie;
    assign w_take_mret = w_idle && !exc_req && !(irq && r_mie) && mret_ex;
    assign w_take_br   = w_idle && !exc_req && !(irq && r_mie) && !mret_ex && br_taken_ex;
    assign w_event     = w_take_exc || w_take_irq || w_take_mret || w_take_br;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state: enter FLUSH on any serviced event, leave when the down-counter expires.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_event) w_state_nxt = FLUSH;
            FLUSH:   if (r_cnt == 2'd0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: redirect select in IDLE, kill while redirecting or flushing, quiet in reset.
    always_comb begin
        pc_sel = SEL_PC4;
        flush  = 1'b0;
        if (rst_n) begin
            if (r_state == FLUSH) begin
                flush = 1'b1;
            end else begin
                flush = w_event;
                if (w_take_exc || w_take_irq) pc_sel = SEL_TVEC;
                else if (w_take_mret)         pc_sel = SEL_EPC;
                else if (w_take_br)           pc_sel = SEL_BR;
            end
        end
    end

    // Kill-window down-counter: loaded on entry, counts down while in FLUSH.
    always_ff @(posedge clk) begin
        if (!rst_n)                              r_cnt <= 2'd0;
        else if (w_event)                        r_cnt <= CNT_LOAD;
        else if (r_state == FLUSH && r_cnt != 0) r_cnt <= r_cnt - 2'd1;
    end

    // mtvec: software-written only; low bits keep the mode flag when vectoring is built in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtvec <= '0;
        end else if (csr_we && csr_addr == ADDR_MTVEC) begin
`ifdef PC_REDIRECT_VECTORED_EN
            r_mtvec <= {csr_wdata[WIDTH-1:2], 1'b0, csr_wdata[0]};
`else
            r_mtvec <= csr_wdata & ALIGN_MASK;
`endif
        end
    end

    // mepc/mcause/mstatus: trap and MRET updates take precedence over a same-cycle CSR write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
        end else if (w_take_exc || w_take_irq) begin
            r_mepc   <= exc_pc & ALIGN_MASK;
            r_mcause <= w_take_irq ? IRQ_MCAUSE : {{(WIDTH-5){1'b0}}, exc_cause};
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_take_mret) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    r_mie  <= csr_wdata[3];
                    r_mpie <= csr_wdata[7];
                end
                ADDR_MEPC:   r_mepc   <= csr_wdata & ALIGN_MASK;
                ADDR_MCAUSE: r_mcause <= csr_wdata;
                default: ;
            endcase
        end
    end

    // Trap-vector presentation: vectored interrupts point at base + 4*cause.
`ifdef PC_REDIRECT_VECTORED_EN
    always_comb begin
        mtvec = r_mtvec;
        if (r_mtvec[0] && w_take_irq)
            mtvec = (r_mtvec & ALIGN_MASK) + WIDTH'(4 * IRQ_CODE);
    end
`else
    assign mtvec = r_mtvec;
`endif

    assign br_target = br_target_in;
    assign mepc      = r_mepc;
    assign mcause    = r_mcause;
    assign mie       = r_mie;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: expectations are queued when stimulus is driven
// and popped against DUT outputs once they settle, one step at a time.
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        br_taken_ex;
    logic [31:0] br_target_in;
    logic        exc_req;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        irq;
    logic        mret_ex;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  pc_sel;
    logic [31:0] br_target;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        mie;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    string       q_tag[$];
    logic [31:0] q_exp[$];

    pc_redirect_ctrl #(.WIDTH(32), .FLUSH_CYCLES(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .br_taken_ex  (br_taken_ex),
        .br_target_in (br_target_in),
        .exc_req      (exc_req),
        .exc_cause    (exc_cause),
        .exc_pc       (exc_pc),
        .irq          (irq),
        .mret_ex      (mret_ex),
        .csr_we       (csr_we),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .pc_sel       (pc_sel),
        .br_target    (br_target),
        .mtvec        (mtvec),
        .mepc         (mepc),
        .mcause       (mcause),
        .mie          (mie),
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        checks++;
        if (q_exp.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            tag = q_tag.pop_front();
            e   = q_exp.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic idle_inputs();
        br_taken_ex  = 1'b0;
        br_target_in = '0;
        exc_req      = 1'b0;
        exc_cause    = '0;
        exc_pc       = '0;
        irq          = 1'b0;
        mret_ex      = 1'b0;
        csr_we       = 1'b0;
        csr_addr     = '0;
        csr_wdata    = '0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_tvec;
        logic [31:0] exp_tvec_irq;
`ifdef PC_REDIRECT_VECTORED_EN
        exp_tvec     = 32'h0000_0201;
        exp_tvec_irq = 32'h0000_022C;
`else
        exp_tvec     = 32'h0000_0200;
        exp_tvec_irq = 32'h0000_0200;
`endif
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();

        // Reset: a branch request is held off and outputs stay quiet.
        br_taken_ex = 1'b1; br_target_in = 32'h100;
        push("rst_pc_sel", 32'd0); push("rst_flush", 32'd0);
        #1; pop_chk(32'(pc_sel)); pop_chk(32'(flush));
        tick();
        push("rst_mtvec", 32'd0); push("rst_mepc", 32'd0);
        push("rst_mcause", 32'd0); push("rst_mie", 32'd0);
        pop_chk(mtvec); pop_chk(mepc); pop_chk(mcause); pop_chk(32'(mie));
        idle_inputs();
        rst_n = 1'b1;
        tick();
        push("idle_flush", 32'd0);
        pop_chk(32'(flush));

        // Branch redirect, then a branch in the flush window is ignored.
        br_taken_ex = 1'b1; br_target_in = 32'h100;
        push("br_pc_sel", 32'd1); push("br_target", 32'h100); push("br_flush", 32'd1);
        #1; pop_chk(32'(pc_sel)); pop_chk(br_target); pop_chk(32'(flush));
        tick();
        br_target_in = 32'h180;
        push("br_fl_pc_sel", 32'd0); push("br_fl_flush", 32'd1);
        #1; pop_chk(32'(pc_sel)); pop_chk(32'(flush));
        tick();
        br_taken_ex = 1'b0;
        push("br_done_flush", 32'd0);
        #1; pop_chk(32'(flush));

        // CSR setup: mtvec low bits, then MIE on.
        csr_wr(12'h305, 32'h203);
        push("mtvec_wr", exp_tvec);
        pop_chk(mtvec);
        csr_wr(12'h300, 32'h8);
        push("mie_wr", 32'd1);
        pop_chk(32'(mie));

        // Exception with simultaneous mret, branch and mepc write: exception wins everything.
        exc_req = 1'b1; exc_cause = 5'd2; exc_pc = 32'h44;
        br_taken_ex = 1'b1; br_target_in = 32'h300; mret_ex = 1'b1;
        csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h999;
        push("exc_pc_sel", 32'd2); push("exc_flush", 32'd1);
        #1; pop_chk(32'(pc_sel)); pop_chk(32'(flush));
        tick();
        idle_inputs();
        push("exc_mepc", 32'h44); push("exc_mcause", 32'd2);
        push("exc_mie", 32'd0); push("exc_fl_flush", 32'd1);
        #1; pop_chk(mepc); pop_chk(mcause); pop_chk(32'(mie)); pop_chk(32'(flush));
        tick();

        // MRET back: MIE restored from MPIE, branch in flush ignored.
        mret_ex = 1'b1;
        push("mret_pc_sel", 32'd3); push("mret_mepc", 32'h44);
        #1; pop_chk(32'(pc_sel)); pop_chk(mepc);
        tick();
        mret_ex = 1'b0; br_taken_ex = 1'b1; br_target_in = 32'h500;
        push("mret_mie", 32'd1); push("mret_fl_pc_sel", 32'd0); push("mret_fl_flush", 32'd1);
        #1; pop_chk(32'(mie)); pop_chk(32'(pc_sel)); pop_chk(32'(flush));
        tick();
        br_taken_ex = 1'b0;

        // Masked interrupt held off, then taken once MIE is set.
        csr_wr(12'h300, 32'h0);
        irq = 1'b1; exc_pc = 32'h86;
        push("irq_masked_pc_sel", 32'd0); push("irq_masked_flush", 32'd0);
        #1; pop_chk(32'(pc_sel)); pop_chk(32'(flush));
        csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h8;
        push("irq_wr_pc_sel", 32'd0);
        #1; pop_chk(32'(pc_sel));
        tick();
        csr_we = 1'b0;
        push("irq_pc_sel", 32'd2); push("irq_mtvec", exp_tvec_irq);
        #1; pop_chk(32'(pc_sel)); pop_chk(mtvec);
        tick();
        irq = 1'b0;
        push("irq_mcause", 32'h8000_000B); push("irq_mepc", 32'h84);
        push("irq_mie", 32'd0); push("irq_fl_flush", 32'd1);
        #1; pop_chk(mcause); pop_chk(mepc); pop_chk(32'(mie)); pop_chk(32'(flush));

        // Reset in the middle of the flush window.
        rst_n = 1'b0;
        push("rstfl_flush_now", 32'd0);
        #1; pop_chk(32'(flush));
        tick();
        push("rstfl_flush", 32'd0); push("rstfl_mtvec", 32'd0);
        push("rstfl_mepc", 32'd0); push("rstfl_mcause", 32'd0);
        pop_chk(32'(flush)); pop_chk(mtvec); pop_chk(mepc); pop_chk(mcause);
        rst_n = 1'b1;
        tick();
        push("post_rst_flush", 32'd0);
        pop_chk(32'(flush));

        // mepc alignment, mcause write and ignored unlisted address.
        csr_wr(12'h341, 32'h57);
        csr_wr(12'h342, 32'h7);
        csr_wr(12'h306, 32'hFFF);
        csr_wr(12'h123, 32'hABC);
        push("mepc_align", 32'h54); push("mcause_wr", 32'h7); push("unlisted_mtvec", 32'd0);
        pop_chk(mepc); pop_chk(mcause); pop_chk(mtvec);

        if (q_exp.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
